// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port BSRAM between three requesters:
//     video fetcher (read-only), CPU (read/write), boot loader (write-only,
//     only while boot_mode = 1). At most one access is issued per cycle.
//     Read data goes back to the requester that issued the read, in issue
//     order, a fixed RD_LAT+1 cycles after the request is accepted.
//   A starvation counter makes sure the CPU gets a slot even under
//   continuous video traffic.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   boot_mode                      1 = boot loader owns writes, CPU blocked
//   v_req/v_addr -> v_gnt          video read request / accept
//   v_rvalid/v_rdata               video read return
//   c_req/c_we/c_addr/c_wdata      CPU request
//   c_gnt, c_rvalid/c_rdata        CPU accept / read return
//   b_req/b_addr/b_wdata -> b_gnt  boot write request / accept
//   mem_ce/mem_we/mem_ad/mem_din   registered BSRAM controls
//   mem_dout                       BSRAM read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_mode,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // Counter is at least 3 bits wide and large enough to hold STARVE_LIMIT.
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  logic [CNT_W-1:0] starve_cnt;
  tag_t             tag_pipe [RD_LAT];
  tag_t             issue_tag;
  logic             c_elig;
  logic             b_elig;
  logic             force_cpu;

  // ---------------------------------------------------------------------
  // Grant logic (combinational). Video > boot > CPU, except that a CPU
  // that has waited STARVE_LIMIT video wins takes the slot from video.
  // Boot and CPU are never eligible together, so the override only ever
  // has to beat video. Grants are held low while in reset.
  // ---------------------------------------------------------------------
  always_comb begin
    c_elig    = ~boot_mode & c_req;
    b_elig    = boot_mode & b_req;
    force_cpu = c_elig & (starve_cnt >= LIMIT);
    v_gnt     = rst_n & v_req & ~force_cpu;
    b_gnt     = rst_n & b_elig & ~v_req;
    c_gnt     = rst_n & c_elig & (force_cpu | ~v_req);
  end

  // Owner of the read (if any) accepted this cycle.
  always_comb begin
    issue_tag = TAG_NONE;
    if (v_gnt) begin
      issue_tag = TAG_VID;
    end else if (c_gnt && !c_we) begin
      issue_tag = TAG_CPU;
    end
  end

  // ---------------------------------------------------------------------
  // Starvation counter: counts video wins while the CPU is waiting.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!c_elig || c_gnt) begin
      starve_cnt <= '0;
    end else if (v_gnt && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Issue stage: the accepted access is presented to the BSRAM from
  // registers one cycle after acceptance. Address/data hold when idle;
  // video reads leave mem_din untouched.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ce  <= 1'b0;
      mem_we  <= 1'b0;
      mem_ad  <= '0;
      mem_din <= '0;
    end else begin
      mem_ce <= v_gnt | b_gnt | c_gnt;
      mem_we <= b_gnt | (c_gnt & c_we);
      if (v_gnt) begin
        mem_ad <= v_addr;
      end else if (b_gnt) begin
        mem_ad  <= b_addr;
        mem_din <= b_wdata;
      end else if (c_gnt) begin
        mem_ad  <= c_addr;
        mem_din <= c_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Owner-tag pipeline. A tag enters stage 0 at acceptance and reaches
  // the last stage in the cycle mem_dout carries that read's data; the
  // return registers below then capture it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe[0] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= issue_tag;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_pipe[gi] <= TAG_NONE;
        end else begin
          tag_pipe[gi] <= tag_pipe[gi-1];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read return: one-cycle rvalid pulse, rdata holds between pulses.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      v_rdata  <= '0;
      c_rdata  <= '0;
    end else begin
      v_rvalid <= (tag_pipe[RD_LAT-1] == TAG_VID);
      c_rvalid <= (tag_pipe[RD_LAT-1] == TAG_CPU);
      if (tag_pipe[RD_LAT-1] == TAG_VID) begin
        v_rdata <= mem_dout;
      end
      if (tag_pipe[RD_LAT-1] == TAG_CPU) begin
        c_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural BSRAM model whose
//   read data appears one clock after the mem_ce cycle, so a read accepted
//   in cycle T returns in T+3 (RD_LAT = 2). Memory is preloaded with
//   pat(addr) = addr[7:0] ^ addr[15:8] ^ 8'h3C.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              boot_mode = 1'b0;
  logic              v_req = 1'b0;
  logic [ADDR_W-1:0] v_addr = '0;
  logic              v_gnt;
  logic              v_rvalid;
  logic [DATA_W-1:0] v_rdata;
  logic              c_req = 1'b0;
  logic              c_we = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [DATA_W-1:0] c_wdata = '0;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              b_req = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_gnt;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode),
    .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt),
    .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_ad(mem_ad), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // BSRAM model
  logic [7:0] bram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) bram[i] = pat(16'(i));
  end
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) bram[mem_ad] <= mem_din;
      else        mem_dout <= bram[mem_ad];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    v_req = 1'b1; c_req = 1'b1; b_req = 1'b0;
    tick; tick;
    vectors++; if (v_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_v_gnt got=%b exp=0", v_gnt); end
    vectors++; if (c_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_c_gnt got=%b exp=0", c_gnt); end
    vectors++; if (b_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_b_gnt got=%b exp=0", b_gnt); end
    vectors++; if (mem_ce !== 1'b0) begin miscompares++; $display("FAIL rst_mem_ce got=%b exp=0", mem_ce); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    vectors++; if (mem_ad !== 16'h0000) begin miscompares++; $display("FAIL rst_mem_ad got=%h exp=0000", mem_ad); end
    vectors++; if (mem_din !== 8'h00) begin miscompares++; $display("FAIL rst_mem_din got=%h exp=00", mem_din); end
    vectors++; if (v_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_v_rvalid got=%b exp=0", v_rvalid); end
    vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_c_rvalid got=%b exp=0", c_rvalid); end
    vectors++; if (v_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_v_rdata got=%h exp=00", v_rdata); end
    vectors++; if (c_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_c_rdata got=%h exp=00", c_rdata); end
    v_req = 1'b0; c_req = 1'b0;
    rst_n = 1'b1;
    tick;
    $display("reset released");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_cpu_read;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0200;
    #1;
    vectors++; if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL cr_c_gnt got=%b exp=1", c_gnt); end
    vectors++; if (v_gnt !== 1'b0 || b_gnt !== 1'b0) begin miscompares++; $display("FAIL cr_other_gnt got=%b%b exp=00", v_gnt, b_gnt); end
    tick;
    c_req = 1'b0;
    vectors++; if (mem_ce !== 1'b1) begin miscompares++; $display("FAIL cr_mem_ce got=%b exp=1", mem_ce); end
    vectors++; if (mem_ad !== 16'h0200) begin miscompares++; $display("FAIL cr_mem_ad got=%h exp=0200", mem_ad); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL cr_mem_we got=%b exp=0", mem_we); end
    tick;
    vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL cr_early_rvalid got=%b exp=0", c_rvalid); end
    tick;
    vectors++; if (c_rvalid !== 1'b1) begin miscompares++; $display("FAIL cr_c_rvalid got=%b exp=1", c_rvalid); end
    vectors++; if (c_rdata !== 8'h3E) begin miscompares++; $display("FAIL cr_c_rdata got=%h exp=3e", c_rdata); end
    vectors++; if (v_rvalid !== 1'b0) begin miscompares++; $display("FAIL cr_v_rvalid got=%b exp=0", v_rvalid); end
    $display("cpu read  addr=0200 data=%h", c_rdata);
    tick;
    vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL cr_pulse_len got=%b exp=0", c_rvalid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_starvation;
    logic [15:0] varr [0:12];
    int   vnext;
    logic exp_v, exp_c, exp_vr, exp_cr;
    vnext = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k < 10) begin
        v_req = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0300;
        v_addr = 16'h2000 + 16'(vnext);
      end else begin
        v_req = 1'b0; c_req = 1'b0;
      end
      #1;
      varr[k] = v_addr;
      exp_c = (k == 4) || (k == 9);
      exp_v = (k < 10) && !exp_c;
      vectors++; if (v_gnt !== exp_v) begin miscompares++; $display("FAIL st_v_gnt k=%0d got=%b exp=%b", k, v_gnt, exp_v); end
      vectors++; if (c_gnt !== exp_c) begin miscompares++; $display("FAIL st_c_gnt k=%0d got=%b exp=%b", k, c_gnt, exp_c); end
      exp_cr = (k - 3 == 4) || (k - 3 == 9);
      exp_vr = (k >= 3) && (k - 3 < 10) && !exp_cr;
      vectors++; if (v_rvalid !== exp_vr) begin miscompares++; $display("FAIL st_v_rvalid k=%0d got=%b exp=%b", k, v_rvalid, exp_vr); end
      vectors++; if (c_rvalid !== exp_cr) begin miscompares++; $display("FAIL st_c_rvalid k=%0d got=%b exp=%b", k, c_rvalid, exp_cr); end
      if (exp_vr) begin
        vectors++; if (v_rdata !== pat(varr[k-3])) begin miscompares++; $display("FAIL st_v_rdata k=%0d got=%h exp=%h", k, v_rdata, pat(varr[k-3])); end
      end
      if (exp_cr) begin
        vectors++; if (c_rdata !== 8'h3F) begin miscompares++; $display("FAIL st_c_rdata k=%0d got=%h exp=3f", k, c_rdata); end
      end
      if (k < 10) $display("contend   k=%0d grant=%s", k, v_gnt ? "V" : (c_gnt ? "C" : "-"));
      if (exp_v) vnext++;
      tick;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_boot_write;
    boot_mode = 1'b1;
    b_req = 1'b1; b_addr = 16'h0200; b_wdata = 8'hA9;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0200;
    #1;
    vectors++; if (b_gnt !== 1'b1) begin miscompares++; $display("FAIL bw_b_gnt got=%b exp=1", b_gnt); end
    vectors++; if (c_gnt !== 1'b0) begin miscompares++; $display("FAIL bw_c_gnt got=%b exp=0", c_gnt); end
    tick;
    b_req = 1'b0;
    #1;
    vectors++; if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin miscompares++; $display("FAIL bw_mem_ce_we got=%b%b exp=11", mem_ce, mem_we); end
    vectors++; if (mem_din !== 8'hA9) begin miscompares++; $display("FAIL bw_mem_din got=%h exp=a9", mem_din); end
    vectors++; if (mem_ad !== 16'h0200) begin miscompares++; $display("FAIL bw_mem_ad got=%h exp=0200", mem_ad); end
    vectors++; if (c_gnt !== 1'b0) begin miscompares++; $display("FAIL bw_c_blocked got=%b exp=0", c_gnt); end
    $display("boot write addr=0200 data=a9");
    boot_mode = 1'b0;
    #1;
    vectors++; if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL bw_c_gnt_after got=%b exp=1", c_gnt); end
    tick;
    c_req = 1'b0;
    vectors++; if (mem_we !== 1'b0 || mem_ce !== 1'b1) begin miscompares++; $display("FAIL bw_read_issue got=%b%b exp=10", mem_ce, mem_we); end
    tick; tick;
    vectors++; if (c_rvalid !== 1'b1) begin miscompares++; $display("FAIL bw_c_rvalid got=%b exp=1", c_rvalid); end
    vectors++; if (c_rdata !== 8'hA9) begin miscompares++; $display("FAIL bw_c_rdata got=%h exp=a9", c_rdata); end
    $display("cpu read  addr=0200 data=%h", c_rdata);
    tick;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back;
    logic exp_r;
    for (int k = 0; k < 8; k++) begin
      v_req = (k < 4);
      v_addr = 16'h1000 + 16'(k);
      #1;
      vectors++; if (v_gnt !== (k < 4)) begin miscompares++; $display("FAIL bb_v_gnt k=%0d got=%b exp=%b", k, v_gnt, (k < 4)); end
      exp_r = (k >= 3) && (k < 7);
      vectors++; if (v_rvalid !== exp_r) begin miscompares++; $display("FAIL bb_v_rvalid k=%0d got=%b exp=%b", k, v_rvalid, exp_r); end
      if (exp_r) begin
        vectors++; if (v_rdata !== pat(16'h1000 + 16'(k - 3))) begin miscompares++; $display("FAIL bb_v_rdata k=%0d got=%h exp=%h", k, v_rdata, pat(16'h1000 + 16'(k - 3))); end
        $display("video read addr=%h data=%h", 16'h1000 + 16'(k - 3), v_rdata);
      end
      tick;
    end
    v_req = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_write_then_read;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0010; c_wdata = 8'h55;
    #1;
    vectors++; if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_c_gnt_w got=%b exp=1", c_gnt); end
    tick;
    c_we = 1'b0;
    #1;
    vectors++; if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_c_gnt_r got=%b exp=1", c_gnt); end
    vectors++; if (mem_we !== 1'b1 || mem_din !== 8'h55) begin miscompares++; $display("FAIL wr_mem_write got=%b/%h exp=1/55", mem_we, mem_din); end
    tick;
    c_req = 1'b0;
    vectors++; if (mem_we !== 1'b0 || mem_ad !== 16'h0010) begin miscompares++; $display("FAIL wr_mem_read got=%b/%h exp=0/0010", mem_we, mem_ad); end
    tick;
    vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_write_rvalid got=%b exp=0", c_rvalid); end
    tick;
    vectors++; if (c_rvalid !== 1'b1) begin miscompares++; $display("FAIL wr_c_rvalid got=%b exp=1", c_rvalid); end
    vectors++; if (c_rdata !== 8'h55) begin miscompares++; $display("FAIL wr_c_rdata got=%h exp=55", c_rdata); end
    $display("cpu w+r   addr=0010 data=%h", c_rdata);
    tick;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid;
    v_req = 1'b1; v_addr = 16'h3000;
    #1;
    vectors++; if (v_gnt !== 1'b1) begin miscompares++; $display("FAIL rm_v_gnt got=%b exp=1", v_gnt); end
    tick;
    v_req = 1'b1; c_req = 1'b1; c_we = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (v_gnt !== 1'b0 || c_gnt !== 1'b0) begin miscompares++; $display("FAIL rm_gnt_in_reset got=%b%b exp=00", v_gnt, c_gnt); end
    vectors++; if (mem_ce !== 1'b0 || mem_ad !== 16'h0000) begin miscompares++; $display("FAIL rm_mem_reset got=%b/%h exp=0/0000", mem_ce, mem_ad); end
    vectors++; if (v_rdata !== 8'h00 || c_rdata !== 8'h00) begin miscompares++; $display("FAIL rm_rdata_reset got=%h/%h exp=00/00", v_rdata, c_rdata); end
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++; if (v_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_v_rvalid_in_reset k=%0d got=%b exp=0", k, v_rvalid); end
    end
    v_req = 1'b0; c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0040; c_wdata = 8'h77;
    rst_n = 1'b1;
    #1;
    vectors++; if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL rm_first_gnt got=%b exp=1", c_gnt); end
    tick;
    c_req = 1'b0;
    vectors++; if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin miscompares++; $display("FAIL rm_first_issue got=%b%b exp=11", mem_ce, mem_we); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (v_rvalid !== 1'b0 || c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_rvalid_after k=%0d got=%b%b exp=00", k, v_rvalid, c_rvalid); end
      tick;
    end
    $display("reset mid-read: aborted video read 3000");
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_starvation();
    test_boot_write();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
